// File: rtl/riscv_pkg.sv
// Shared opcode constants, write-back encodings, FSM state type and instruction class for the multicycle controller.
// The TRAP state only exists when MULTICYCLE_CTRL_TRAP_EN is defined.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
`ifdef MULTICYCLE_CTRL_TRAP_EN
        WB     = 3'd4,
        TRAP   = 3'd5
`else
        WB     = 3'd4
`endif
    } state_t;

    // One-hot classification of the latched opcode; exactly one field is set.
    typedef struct packed {
        logic i_op;
        logic load;
        logic store;
        logic branch;
        logic lui;
        logic jal;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classifier: maps the 7-bit opcode field onto an instruction class.
module ctrl_decode
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP_IMM: cls.i_op    = 1'b1;
            OPC_LOAD:   cls.load    = 1'b1;
            OPC_STORE:  cls.store   = 1'b1;
            OPC_BRANCH: cls.branch  = 1'b1;
            OPC_LUI:    cls.lui     = 1'b1;
            OPC_JAL:    cls.jal     = 1'b1;
            default:    cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing of datapath strobes.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on unknown opcodes (TRAP state, illegal_instr port); otherwise they retire as NOPs.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_data_sel,
    output logic        ir_we,
    output logic [6:0]  imm_type,
    output logic        alu_src_imm,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
`ifdef MULTICYCLE_CTRL_TRAP_EN
    output logic        retire,
    output logic        illegal_instr
`else
    output logic        retire
`endif
);

    state_t       state;
    state_t       state_next;
    logic [6:0]   ir_opcode;
    instr_class_t cls;

    // Only the opcode field steers control; the remaining instruction bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[31:7];

    ctrl_decode u_decode (
        .opcode (ir_opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            ir_opcode <= '0;
        end else begin
            state <= state_next;
            if (ir_we) begin
                ir_opcode <= instr_in[6:0];
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_data_sel = 1'b0;
        ir_we        = 1'b0;
        imm_type     = ir_opcode;
        alu_src_imm  = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_SEL_ALU;
        retire       = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        illegal_instr = 1'b0;
`endif

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                state_next = EXEC;
            end

            EXEC: begin
                alu_src_imm = cls.i_op | cls.load | cls.store;
                if (cls.i_op | cls.lui | cls.jal) begin
                    state_next = WB;
                end else if (cls.load | cls.store) begin
                    state_next = MEM;
                end else if (cls.branch) begin
                    pc_we      = 1'b1;
                    pc_sel     = branch_cond;
                    retire     = 1'b1;
                    state_next = FETCH;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_next = TRAP;
`else
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = FETCH;
`endif
                end
            end

            // Only loads and stores reach MEM, so the immediate operand is always selected here.
            MEM: begin
                mem_req      = 1'b1;
                mem_data_sel = 1'b1;
                mem_we       = cls.store;
                alu_src_imm  = 1'b1;
                if (mem_ready) begin
                    if (cls.store) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end

            WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                pc_sel     = cls.jal;
                state_next = FETCH;
                if (cls.load) begin
                    wb_sel = WB_SEL_MEM;
                end else if (cls.lui) begin
                    wb_sel = WB_SEL_IMM;
                end else if (cls.jal) begin
                    wb_sel = WB_SEL_PC4;
                end
            end

`ifdef MULTICYCLE_CTRL_TRAP_EN
            TRAP: begin
                illegal_instr = 1'b1;
                imm_type      = '0;
            end
`endif

            default: begin
                state_next = FETCH;
            end
        endcase

        // Reset silences every output at once, so a pending access or a late mem_ready has no effect.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_data_sel = 1'b0;
            ir_we        = 1'b0;
            imm_type     = '0;
            alu_src_imm  = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = 1'b0;
            reg_we       = 1'b0;
            wb_sel       = WB_SEL_ALU;
            retire       = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one expected output vector per clock cycle, hand-derived per instruction class.
// Covers the MULTICYCLE_CTRL_TRAP_EN build and the default NOP build.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic        mem_ready;
    logic        branch_cond;
    logic        mem_req;
    logic        mem_we;
    logic        mem_data_sel;
    logic        ir_we;
    logic [6:0]  imm_type;
    logic        alu_src_imm;
    logic        pc_we;
    logic        pc_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic        illegal_instr;
`endif

    int check_count = 0;
    int error_count = 0;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .mem_ready    (mem_ready),
        .branch_cond  (branch_cond),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_data_sel (mem_data_sel),
        .ir_we        (ir_we),
        .imm_type     (imm_type),
        .alu_src_imm  (alu_src_imm),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
`ifdef MULTICYCLE_CTRL_TRAP_EN
        .retire       (retire),
        .illegal_instr(illegal_instr)
`else
        .retire       (retire)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: mem_req mem_we mem_data_sel ir_we imm_type alu_src_imm pc_we pc_sel reg_we wb_sel retire
    function automatic logic [17:0] mk(input logic mreq, input logic mwe, input logic msel,
                                       input logic irwe, input logic [6:0] imm, input logic alu,
                                       input logic pcwe, input logic pcsel, input logic regwe,
                                       input logic [1:0] wb, input logic ret);
        return {mreq, mwe, msel, irwe, imm, alu, pcwe, pcsel, regwe, wb, ret};
    endfunction

    function automatic logic [17:0] observed();
        return {mem_req, mem_we, mem_data_sel, ir_we, imm_type, alu_src_imm,
                pc_we, pc_sel, reg_we, wb_sel, retire};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_count++;
        if (obs !== exp_v) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
    task automatic applyStimulus(input logic r, input logic rdy, input logic [31:0] ins, input logic bc);
        @(negedge clk);
        rst         = r;
        mem_ready   = rdy;
        instr_in    = ins;
        branch_cond = bc;
        #1;
    endtask

    task automatic expectCycle(input string tag, input logic r, input logic rdy,
                               input logic [31:0] ins, input logic bc, input logic [17:0] exp_v);
        applyStimulus(r, rdy, ins, bc);
        checkOutput(tag, {14'd0, observed()}, {14'd0, exp_v});
    endtask

    initial begin
        rst         = 1'b1;
        mem_ready   = 1'b0;
        instr_in    = '0;
        branch_cond = 1'b0;

        expectCycle("reset0",       1, 1, I_ADDI, 0, 18'h0);
        expectCycle("reset1",       1, 1, I_ADDI, 0, 18'h0);

        expectCycle("addi_fetch",   0, 1, I_ADDI, 0, mk(1,0,0,1,7'h00,0,0,0,0,2'b00,0));
        expectCycle("addi_decode",  0, 1, I_ADDI, 0, mk(0,0,0,0,7'h13,0,0,0,0,2'b00,0));
        expectCycle("addi_exec",    0, 1, I_ADDI, 0, mk(0,0,0,0,7'h13,1,0,0,0,2'b00,0));
        expectCycle("addi_wb",      0, 1, I_ADDI, 0, mk(0,0,0,0,7'h13,0,1,0,1,2'b00,1));

        expectCycle("lw_fetch",     0, 1, I_LW,   0, mk(1,0,0,1,7'h13,0,0,0,0,2'b00,0));
        expectCycle("lw_decode",    0, 1, I_LW,   0, mk(0,0,0,0,7'h03,0,0,0,0,2'b00,0));
        expectCycle("lw_exec",      0, 1, I_LW,   0, mk(0,0,0,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw_mem_wait0", 0, 0, I_LW,   0, mk(1,0,1,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw_mem_wait1", 0, 0, I_LW,   0, mk(1,0,1,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw_mem_wait2", 0, 0, I_LW,   0, mk(1,0,1,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw_mem_ready", 0, 1, I_LW,   0, mk(1,0,1,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw_wb",        0, 1, I_LW,   0, mk(0,0,0,0,7'h03,0,1,0,1,2'b01,1));

        expectCycle("sw_fetch",     0, 1, I_SW,   0, mk(1,0,0,1,7'h03,0,0,0,0,2'b00,0));
        expectCycle("sw_decode",    0, 1, I_SW,   0, mk(0,0,0,0,7'h23,0,0,0,0,2'b00,0));
        expectCycle("sw_exec",      0, 1, I_SW,   0, mk(0,0,0,0,7'h23,1,0,0,0,2'b00,0));
        expectCycle("sw_mem",       0, 1, I_SW,   0, mk(1,1,1,0,7'h23,1,1,0,0,2'b00,1));

        expectCycle("beq1_fetch",   0, 1, I_BEQ,  1, mk(1,0,0,1,7'h23,0,0,0,0,2'b00,0));
        expectCycle("beq1_decode",  0, 1, I_BEQ,  1, mk(0,0,0,0,7'h63,0,0,0,0,2'b00,0));
        expectCycle("beq1_exec",    0, 1, I_BEQ,  1, mk(0,0,0,0,7'h63,0,1,1,0,2'b00,1));
        expectCycle("beq0_fetch",   0, 1, I_BEQ,  0, mk(1,0,0,1,7'h63,0,0,0,0,2'b00,0));
        expectCycle("beq0_decode",  0, 1, I_BEQ,  0, mk(0,0,0,0,7'h63,0,0,0,0,2'b00,0));
        expectCycle("beq0_exec",    0, 1, I_BEQ,  0, mk(0,0,0,0,7'h63,0,1,0,0,2'b00,1));

        expectCycle("lui_fetch",    0, 1, I_LUI,  0, mk(1,0,0,1,7'h63,0,0,0,0,2'b00,0));
        expectCycle("lui_decode",   0, 1, I_LUI,  0, mk(0,0,0,0,7'h37,0,0,0,0,2'b00,0));
        expectCycle("lui_exec",     0, 1, I_LUI,  0, mk(0,0,0,0,7'h37,0,0,0,0,2'b00,0));
        expectCycle("lui_wb",       0, 1, I_LUI,  0, mk(0,0,0,0,7'h37,0,1,0,1,2'b11,1));

        expectCycle("jal_fetch",    0, 1, I_JAL,  0, mk(1,0,0,1,7'h37,0,0,0,0,2'b00,0));
        expectCycle("jal_decode",   0, 1, I_JAL,  0, mk(0,0,0,0,7'h6F,0,0,0,0,2'b00,0));
        expectCycle("jal_exec",     0, 1, I_JAL,  0, mk(0,0,0,0,7'h6F,0,0,0,0,2'b00,0));
        expectCycle("jal_wb",       0, 1, I_JAL,  0, mk(0,0,0,0,7'h6F,0,1,1,1,2'b10,1));

        expectCycle("fetch_wait",   0, 0, I_LW,   0, mk(1,0,0,0,7'h6F,0,0,0,0,2'b00,0));
        expectCycle("fetch_ready",  0, 1, I_LW,   0, mk(1,0,0,1,7'h6F,0,0,0,0,2'b00,0));
        expectCycle("lw2_decode",   0, 1, I_LW,   0, mk(0,0,0,0,7'h03,0,0,0,0,2'b00,0));
        expectCycle("lw2_exec",     0, 1, I_LW,   0, mk(0,0,0,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("lw2_mem_wait", 0, 0, I_LW,   0, mk(1,0,1,0,7'h03,1,0,0,0,2'b00,0));
        expectCycle("rst_mid_mem",  1, 1, I_LW,   0, 18'h0);
        expectCycle("post_rst",     0, 0, I_ILL,  0, mk(1,0,0,0,7'h00,0,0,0,0,2'b00,0));

        expectCycle("ill_fetch",    0, 1, I_ILL,  0, mk(1,0,0,1,7'h00,0,0,0,0,2'b00,0));
        expectCycle("ill_decode",   0, 1, I_ILL,  0, mk(0,0,0,0,7'h7F,0,0,0,0,2'b00,0));
`ifdef MULTICYCLE_CTRL_TRAP_EN
        expectCycle("ill_exec",     0, 1, I_ADDI, 0, mk(0,0,0,0,7'h7F,0,0,0,0,2'b00,0));
        checkOutput("ill_exec_flag", {31'd0, illegal_instr}, 32'd0);
        expectCycle("trap0",        0, 1, I_ADDI, 0, 18'h0);
        checkOutput("trap0_flag",   {31'd0, illegal_instr}, 32'd1);
        expectCycle("trap1",        0, 1, I_ADDI, 1, 18'h0);
        checkOutput("trap1_flag",   {31'd0, illegal_instr}, 32'd1);
        expectCycle("trap_rst",     1, 1, I_ADDI, 0, 18'h0);
        checkOutput("trap_rst_flag", {31'd0, illegal_instr}, 32'd0);
        expectCycle("trap_refetch", 0, 1, I_ADDI, 0, mk(1,0,0,1,7'h00,0,0,0,0,2'b00,0));
        checkOutput("refetch_flag", {31'd0, illegal_instr}, 32'd0);
`else
        expectCycle("ill_exec_nop", 0, 1, I_ADDI, 0, mk(0,0,0,0,7'h7F,0,1,0,0,2'b00,1));
        expectCycle("ill_refetch",  0, 1, I_ADDI, 0, mk(1,0,0,1,7'h7F,0,0,0,0,2'b00,0));
        expectCycle("ill_next_dec", 0, 1, I_ADDI, 0, mk(0,0,0,0,7'h13,0,0,0,0,2'b00,0));
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
